// File: rtl/inverse_butterfly_pipe.sv
// Pipelined radix-2 inverse butterfly: recovers A = (X+Y)/2 and
// B = (X-Y)*conj(W)/2 from forward butterfly outputs, over three stages
// with valid/ready flow control and a sticky saturation flag.
module inverse_butterfly_pipe #(
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inputX,
  input  logic [WIDTH-1:0] inputY,
  input  logic [WIDTH-1:0] twiddle,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             outLast,
  output logic             satFlag,
  input  logic             clearSat
);

  localparam int unsigned H  = WIDTH / 2;   // half (component) width
  localparam int unsigned SW = H + 1;       // sum/difference width
  localparam int unsigned PW = 2 * H + 1;   // single product width
  localparam int unsigned QW = 2 * H + 2;   // product-sum width
  localparam int unsigned RW = H + 2;       // width after rounding shift

  localparam logic signed [QW-1:0] RND     = QW'(1) << (H - 1);
  localparam logic        [H-1:0]  SAT_MAX = {1'b0, {(H-1){1'b1}}};
  localparam logic        [H-1:0]  SAT_MIN = {1'b1, {(H-1){1'b0}}};

  // ---------------------------------------------------------------
  // Flow control: every stage moves together when the output slot frees up
  // ---------------------------------------------------------------
  logic advance_c;
  logic out_valid_q;

  assign advance_c = !out_valid_q || outReady;
  assign inReady   = advance_c;

  // ---------------------------------------------------------------
  // Stage 1: half-wise sum and difference, twiddle capture
  // ---------------------------------------------------------------
  logic signed [H-1:0]  x_re, x_im, y_re, y_im, w_re, w_im;
  logic signed [SW-1:0] s1_sr_d, s1_si_d, s1_dr_d, s1_di_d;
  logic signed [SW-1:0] s1_sr_q, s1_si_q, s1_dr_q, s1_di_q;
  logic signed [H-1:0]  s1_wr_q, s1_wi_q;
  logic                 v1_q, last1_q;

  assign x_re = inputX[WIDTH-1:H];
  assign x_im = inputX[H-1:0];
  assign y_re = inputY[WIDTH-1:H];
  assign y_im = inputY[H-1:0];
  assign w_re = twiddle[WIDTH-1:H];
  assign w_im = twiddle[H-1:0];

  // Sign-extended sum and difference of the incoming pair
  always_comb begin
    s1_sr_d = SW'(x_re) + SW'(y_re);
    s1_si_d = SW'(x_im) + SW'(y_im);
    s1_dr_d = SW'(x_re) - SW'(y_re);
    s1_di_d = SW'(x_im) - SW'(y_im);
  end

  // Stage-1 register; data only loads with a valid word
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      s1_sr_q <= '0;
      s1_si_q <= '0;
      s1_dr_q <= '0;
      s1_di_q <= '0;
      s1_wr_q <= '0;
      s1_wi_q <= '0;
    end else if (advance_c) begin
      v1_q    <= inValid;
      last1_q <= inValid & inLast;
      if (inValid) begin
        s1_sr_q <= s1_sr_d;
        s1_si_q <= s1_si_d;
        s1_dr_q <= s1_dr_d;
        s1_di_q <= s1_di_d;
        s1_wr_q <= w_re;
        s1_wi_q <= w_im;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: four partial products and halved sum
  // ---------------------------------------------------------------
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [H-1:0]  a_re_d, a_im_d, a_re_q, a_im_q;
  logic                 v2_q, last2_q;

  // Products of D with W; floor-halved S always fits in H bits
  always_comb begin
    p_rr_d = PW'(s1_dr_q) * PW'(s1_wr_q);
    p_ii_d = PW'(s1_di_q) * PW'(s1_wi_q);
    p_ir_d = PW'(s1_di_q) * PW'(s1_wr_q);
    p_ri_d = PW'(s1_dr_q) * PW'(s1_wi_q);
    a_re_d = H'(s1_sr_q >>> 1);
    a_im_d = H'(s1_si_q >>> 1);
  end

  // Stage-2 register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      p_rr_q  <= '0;
      p_ii_q  <= '0;
      p_ir_q  <= '0;
      p_ri_q  <= '0;
      a_re_q  <= '0;
      a_im_q  <= '0;
    end else if (advance_c) begin
      v2_q    <= v1_q;
      last2_q <= v1_q & last1_q;
      if (v1_q) begin
        p_rr_q <= p_rr_d;
        p_ii_q <= p_ii_d;
        p_ir_q <= p_ir_d;
        p_ri_q <= p_ri_d;
        a_re_q <= a_re_d;
        a_im_q <= a_im_d;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 3: combine products, round-half-up, scale, saturate
  // ---------------------------------------------------------------
  logic signed [QW-1:0] pr_c, pi_c, rr_c, ri_c;
  logic signed [RW-1:0] sh_r_c, sh_i_c;
  logic                 ovf_r_c, ovf_i_c;
  logic        [H-1:0]  b_re_c, b_im_c;
  logic [WIDTH-1:0]     out_a_q, out_b_q;
  logic                 out_last_q, sat_flag_q, sat_flag_d;

  // Shift by H folds the Q1.(H-1) twiddle scale and the divide by two
  always_comb begin
    pr_c    = QW'(p_rr_q) + QW'(p_ii_q);
    pi_c    = QW'(p_ir_q) - QW'(p_ri_q);
    rr_c    = pr_c + RND;
    ri_c    = pi_c + RND;
    sh_r_c  = RW'(rr_c >>> H);
    sh_i_c  = RW'(ri_c >>> H);
    ovf_r_c = !((&sh_r_c[RW-1:H-1]) || !(|sh_r_c[RW-1:H-1]));
    ovf_i_c = !((&sh_i_c[RW-1:H-1]) || !(|sh_i_c[RW-1:H-1]));
    b_re_c  = sh_r_c[H-1:0];
    b_im_c  = sh_i_c[H-1:0];
    if (ovf_r_c) b_re_c = sh_r_c[RW-1] ? SAT_MIN : SAT_MAX;
    if (ovf_i_c) b_im_c = sh_i_c[RW-1] ? SAT_MIN : SAT_MAX;
  end

  // Sticky saturation flag: a new saturating load wins over a clear
  always_comb begin
    sat_flag_d = (sat_flag_q & ~clearSat) |
                 (advance_c & v2_q & (ovf_r_c | ovf_i_c));
  end

  // Output register; holds while the downstream stalls
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
      if (advance_c) begin
        out_valid_q <= v2_q;
        out_last_q  <= v2_q & last2_q;
        if (v2_q) begin
          out_a_q <= {a_re_q, a_im_q};
          out_b_q <= {b_re_c, b_im_c};
        end
      end
    end
  end

  assign outValid = out_valid_q;
  assign outLast  = out_last_q;
  assign outA     = out_a_q;
  assign outB     = out_b_q;
  assign satFlag  = sat_flag_q;

endmodule

// File: tb/tb_inverse_butterfly_pipe.sv
// Directed bench for inverse_butterfly_pipe (WIDTH = 36).
module tb_inverse_butterfly_pipe;

  localparam int W = 36;
  localparam int H = 18;

  logic         clk, resetN, inValid, inReady, inLast, outValid, outReady;
  logic         outLast, satFlag, clearSat;
  logic [W-1:0] inputX, inputY, twiddle, outA, outB;

  inverse_butterfly_pipe #(.WIDTH(W)) dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inputX(inputX), .inputY(inputY), .twiddle(twiddle), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .outA(outA), .outB(outB),
    .outLast(outLast), .satFlag(satFlag), .clearSat(clearSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         ql[$];

  // Capture every completed output transfer
  always @(posedge clk) begin
    if (resetN && outValid && outReady) begin
      qa.push_back(outA);
      qb.push_back(outB);
      ql.push_back(outLast);
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pk(input longint re, input longint im);
    logic [H-1:0] r, i;
    r = re[H-1:0];
    i = im[H-1:0];
    return {r, i};
  endfunction

  function automatic longint hre(input logic [W-1:0] v);
    return longint'($signed(v[W-1:H]));
  endfunction

  function automatic longint him(input logic [W-1:0] v);
    return longint'($signed(v[H-1:0]));
  endfunction

  // Floor division for a positive divisor
  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic logic [W-1:0] model_a(input logic [W-1:0] x, input logic [W-1:0] y);
    return pk(fdiv(hre(x) + hre(y), 2), fdiv(him(x) + him(y), 2));
  endfunction

  function automatic logic [W-1:0] model_b(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] w);
    longint dr, di, pr, pi;
    dr = hre(x) - hre(y);
    di = him(x) - him(y);
    pr = dr * hre(w) + di * him(w);
    pi = di * hre(w) - dr * him(w);
    return pk(clampv(fdiv(pr + 131072, 262144)), clampv(fdiv(pi + 131072, 262144)));
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pair for a single cycle (pipeline assumed ready)
  task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] w, input logic l);
    inValid = 1'b1; inputX = x; inputY = y; twiddle = w; inLast = l;
    @(negedge clk);
    inValid = 1'b0; inLast = 1'b0;
  endtask

  logic [W-1:0] sx[5], sy[5], sw[5];

  // Stream n table pairs; optional stall after three accepts, random ready gaps
  task automatic stream(input int n, input bit do_stall, input bit rnd, input bit use_last,
                        input string tag);
    int idx, cyc, base;
    bit acc, stalled;
    base = qa.size(); idx = 0; cyc = 0; stalled = 1'b0;
    while (idx < n && cyc < 300) begin
      inValid = 1'b1; inputX = sx[idx]; inputY = sy[idx]; twiddle = sw[idx];
      inLast = use_last && (idx == n - 1);
      if (rnd) outReady = 1'($urandom_range(0, 1));
      #1 acc = inReady;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
      if (do_stall && !stalled && idx == 3) begin
        stalled = 1'b1;
        chk({tag, "_inready_drop"}, W'(inReady), W'(0));
        chk({tag, "_stall_valid"}, W'(outValid), W'(1));
        chk({tag, "_stall_a0"}, outA, model_a(sx[0], sy[0]));
        chk({tag, "_stall_b0"}, outB, model_b(sx[0], sy[0], sw[0]));
        repeat (4) @(negedge clk);
        chk({tag, "_hold_a"}, outA, model_a(sx[0], sy[0]));
        chk({tag, "_hold_b"}, outB, model_b(sx[0], sy[0], sw[0]));
        chk({tag, "_hold_inready"}, W'(inReady), W'(0));
        outReady = 1'b1;
      end
    end
    inValid = 1'b0; inLast = 1'b0;
    while (qa.size() < base + n && cyc < 600) begin
      if (rnd) outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    outReady = 1'b1;
    repeat (5) @(negedge clk);
    chk({tag, "_count"}, W'(qa.size() - base), W'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < qa.size()) begin
        chk($sformatf("%s_a%0d", tag, k), qa[base+k], model_a(sx[k], sy[k]));
        chk($sformatf("%s_b%0d", tag, k), qb[base+k], model_b(sx[k], sy[k], sw[k]));
        chk($sformatf("%s_last%0d", tag, k), W'(ql[base+k]), W'(use_last && (k == n - 1)));
      end
    end
  endtask

  initial begin
    int base;
    sx[0] = pk(1000, -500);    sy[0] = pk(200, 300);      sw[0] = pk(92682, -92682);
    sx[1] = pk(-7000, 123);    sy[1] = pk(3000, -77);     sw[1] = pk(131071, 0);
    sx[2] = pk(50000, 60000);  sy[2] = pk(-40000, 10000); sw[2] = pk(0, 131071);
    sx[3] = pk(-1, 1);         sy[3] = pk(2, -2);         sw[3] = pk(-131072, 0);
    sx[4] = pk(12345, -23456); sy[4] = pk(-3456, 4567);   sw[4] = pk(65536, 113512);

    resetN = 1'b0; inValid = 1'b0; inLast = 1'b0; outReady = 1'b1; clearSat = 1'b0;
    inputX = '0; inputY = '0; twiddle = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_outvalid", W'(outValid), W'(0));
    chk("rst_outlast", W'(outLast), W'(0));
    chk("rst_sat", W'(satFlag), W'(0));
    chk("rst_outa", outA, W'(0));
    chk("rst_outb", outB, W'(0));
    chk("rst_inready", W'(inReady), W'(1));
    resetN = 1'b1;
    @(negedge clk);

    // Real twiddle near +1, with latency
    send_one(pk(300, 0), pk(100, 0), pk(131071, 0), 1'b0);
    chk("t1_lat1", W'(outValid), W'(0));
    @(negedge clk);
    chk("t1_lat2", W'(outValid), W'(0));
    @(negedge clk);
    chk("t1_valid", W'(outValid), W'(1));
    chk("t1_a", outA, pk(200, 0));
    chk("t1_b", outB, pk(100, 0));
    chk("t1_sat", W'(satFlag), W'(0));
    @(negedge clk);
    chk("t1_single", W'(outValid), W'(0));

    // Twiddle -j
    send_one(pk(300, 0), pk(100, 0), pk(0, -131072), 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_valid", W'(outValid), W'(1));
    chk("t2_a", outA, pk(200, 0));
    chk("t2_b", outB, pk(0, 100));

    // Saturating pair, then sticky flag across a clean pair
    @(negedge clk);
    send_one(pk(131071, 131071), pk(-131072, -131072), pk(-131072, -131072), 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_a", outA, pk(-1, -1));
    chk("t3_b", outB, pk(-131072, 0));
    chk("t3_sat", W'(satFlag), W'(1));
    @(negedge clk);
    send_one(pk(300, 0), pk(100, 0), pk(131071, 0), 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_clean_b", outB, pk(100, 0));
    chk("t3_sticky", W'(satFlag), W'(1));
    clearSat = 1'b1;
    @(negedge clk);
    clearSat = 1'b0;
    chk("t3_cleared", W'(satFlag), W'(0));
    repeat (3) @(negedge clk);

    // Backpressure with five pairs
    outReady = 1'b0;
    stream(5, 1'b1, 1'b0, 1'b0, "bp");

    // Frame end on the fourth pair with random ready gaps
    stream(4, 1'b0, 1'b1, 1'b1, "last");

    // Asynchronous reset with pairs in flight
    outReady = 1'b0;
    inValid = 1'b1; inputX = pk(131071, 131071); inputY = pk(-131072, -131072);
    twiddle = pk(-131072, -131072); inLast = 1'b1;
    @(negedge clk);
    inputX = sx[0]; inputY = sy[0]; twiddle = sw[0]; inLast = 1'b0;
    @(negedge clk);
    inputX = sx[1]; inputY = sy[1]; twiddle = sw[1];
    @(negedge clk);
    inValid = 1'b0;
    chk("mr_pre_valid", W'(outValid), W'(1));
    chk("mr_pre_last", W'(outLast), W'(1));
    chk("mr_pre_sat", W'(satFlag), W'(1));
    #2 resetN = 1'b0;
    #1;
    chk("mr_valid", W'(outValid), W'(0));
    chk("mr_last", W'(outLast), W'(0));
    chk("mr_sat", W'(satFlag), W'(0));
    chk("mr_outa", outA, W'(0));
    @(negedge clk);
    resetN = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    base = qa.size();
    send_one(sx[2], sy[2], sw[2], 1'b0);
    chk("mr_lat1", W'(outValid), W'(0));
    @(negedge clk);
    chk("mr_lat2", W'(outValid), W'(0));
    @(negedge clk);
    chk("mr_valid_after", W'(outValid), W'(1));
    chk("mr_a", outA, model_a(sx[2], sy[2]));
    chk("mr_b", outB, model_b(sx[2], sy[2], sw[2]));
    @(negedge clk);
    chk("mr_alone", W'(outValid), W'(0));
    repeat (3) @(negedge clk);
    chk("mr_count", W'(qa.size() - base), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
